divider_ctrl: RTL and testbench

Run/stop and rate controller for the board's clock-divider path. It produces a 50%-duty divided square wave `clock_out` and a one-cycle `tick` enable. The divide ratio is accepted through a valid/ready handshake and applied only at a period boundary, so `clock_out` never glitches. Starting and stopping are also glitch-free. It replaces fixed-ratio dividers wherever display scan or debounce logic needs a runtime-selectable rate.

---
 rtl/divider_ctrl.sv | 117 +++++++++++
 tb/tb_divider_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/divider_ctrl.sv
// rtl/divider_ctrl.sv - run/stop and rate controller for a glitch-free 50% clock divider
//
// Purpose: divides clock_in by 2*(H+1). The ratio H is taken over a
// valid/ready handshake and applied only at a period boundary. Start and
// stop are also glitch-free.
// Ports:
//   clock_in  - system clock; all logic runs on its rising edge
//   reset     - synchronous, active-high reset
//   run       - level: 1 = run the divided clock, 0 = stop
//   cfg_valid - a new half-period is offered on cfg_half
//   cfg_half  - half-period H; clock_out toggles every H+1 cycles
//   cfg_ready - the controller can accept cfg_half (no config is pending)
//   clock_out - registered divided clock
//   tick      - one-cycle pulse in the first high cycle of clock_out
//   active    - the controller is not idle
//   pending   - an accepted config is waiting for a period boundary
module divider_ctrl #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DEFAULT_HALF = 1
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             clock_out,
  output logic             tick,
  output logic             active,
  output logic             pending
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] half_q;
  logic [CNT_W-1:0] shadow_q;
  logic             pending_q;
  logic             clk_q;
  logic             tick_q;

  logic running;
  logic toggle;
  logic boundary;
  logic xfer;
  logic go_idle;

  assign running  = (state_q != IDLE);
  assign toggle   = running && (cnt_q == half_q);
  // A falling toggle closes a full period; only there may the ratio change.
  assign boundary = toggle & clk_q;
  assign xfer     = cfg_valid & ~pending_q;
  // Stop only once clock_out is, or is about to be, low: either low and not
  // rising now, or high and falling now. A rising toggle with run=0 still
  // completes, and the controller then waits out the high phase.
  assign go_idle  = running & ~run & ~(clk_q ^ toggle);

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      half_q    <= CNT_W'(DEFAULT_HALF);
      shadow_q  <= '0;
      pending_q <= 1'b0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
          // Nothing is running, so a new ratio can be applied directly.
          if (xfer) half_q <= cfg_half;
          if (run) state_q <= RUN;
        end
        default: begin  // RUN or STOPPING
          if (go_idle) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
            pending_q <= 1'b0;
            // Both branches cannot fire together, because xfer requires
            // pending_q == 0.
            if (xfer)           half_q <= cfg_half;
            else if (pending_q) half_q <= shadow_q;
          end else begin
            // From STOPPING with run=1, return to RUN without disturbing
            // the phase.
            state_q <= run ? RUN : STOPPING;
            cnt_q   <= toggle ? '0 : cnt_q + CNT_W'(1);
            clk_q   <= clk_q ^ toggle;
            tick_q  <= toggle & ~clk_q;
            if (boundary && pending_q) begin
              half_q    <= shadow_q;
              pending_q <= 1'b0;
            end
            // A transfer accepted on a boundary waits for the next boundary.
            if (xfer) begin
              shadow_q  <= cfg_half;
              pending_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign cfg_ready = ~pending_q;
  assign clock_out = clk_q;
  assign tick      = tick_q;
  assign active    = running;
  assign pending   = pending_q;

endmodule

// File: tb/tb_divider_ctrl.sv
// tb/tb_divider_ctrl.sv - self-checking bench for divider_ctrl
module tb_divider_ctrl;

  logic        clock_in = 1'b0;
  logic        reset    = 1'b1;
  logic        run      = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [15:0] cfg_half = '0;
  logic        cfg_ready;
  logic        clock_out;
  logic        tick;
  logic        active;
  logic        pending;

  divider_ctrl #(.CNT_W(16), .DEFAULT_HALF(1)) dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .run       (run),
    .cfg_valid (cfg_valid),
    .cfg_half  (cfg_half),
    .cfg_ready (cfg_ready),
    .clock_out (clock_out),
    .tick      (tick),
    .active    (active),
    .pending   (pending)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    bit          rst;
    bit          run;
    bit          cv;
    logic [15:0] half;
    bit          e_clk;
    bit          e_tick;
    bit          e_act;
    bit          e_pend;
  } vec_t;

  typedef struct {
    bit e_clk;
    bit e_tick;
    bit e_act;
    bit e_pend;
    int cyc;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  function automatic vec_t mk(bit rst, bit r, bit cv, logic [15:0] h,
                              bit c, bit t, bit a, bit p);
    vec_t v;
    v.rst = rst; v.run = r; v.cv = cv; v.half = h;
    v.e_clk = c; v.e_tick = t; v.e_act = a; v.e_pend = p;
    return v;
  endfunction

  function automatic void add(bit rst, bit r, bit cv, logic [15:0] h,
                              bit c, bit t, bit a, bit p);
    tbl.push_back(mk(rst, r, cv, h, c, t, a, p));
  endfunction

  // n identical cycles with no config offered
  function automatic void add_n(int n, bit r, bit c, bit t, bit a, bit p);
    for (int i = 0; i < n; i++) tbl.push_back(mk(1'b0, r, 1'b0, 16'd0, c, t, a, p));
  endfunction

  task automatic chk(string nm, int c, logic got, logic exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0b expected=%0b", nm, c, got, exp_v);
    end
  endtask

  task automatic apply(vec_t v);
    exp_t e;
    @(negedge clock_in);
    reset     = v.rst;
    run       = v.run;
    cfg_valid = v.cv;
    cfg_half  = v.half;
    e.e_clk = v.e_clk; e.e_tick = v.e_tick; e.e_act = v.e_act; e.e_pend = v.e_pend;
    e.cyc = cyc;
    sb.push_back(e);
    @(posedge clock_in);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty cycle=%0d got=0 expected=1", cyc);
    end else begin
      e = sb.pop_front();
      chk("clock_out", e.cyc, clock_out, e.e_clk);
      chk("tick",      e.cyc, tick,      e.e_tick);
      chk("active",    e.cyc, active,    e.e_act);
      chk("pending",   e.cyc, pending,   e.e_pend);
      chk("cfg_ready", e.cyc, cfg_ready, ~e.e_pend);
    end
    cyc++;
  endtask

  initial begin
    // Test 1: reset, then run at default H=1 (period 4, 2 high / 2 low)
    add(1, 0, 0, 0,  0, 0, 0, 0);
    add(0, 1, 0, 0,  0, 0, 1, 0);   // RUN entry
    add_n(1, 1,  0, 0, 1, 0);
    add_n(1, 1,  1, 1, 1, 0);       // rise at entry+2
    add_n(1, 1,  1, 0, 1, 0);
    add_n(2, 1,  0, 0, 1, 0);
    add_n(1, 1,  1, 1, 1, 0);
    add_n(1, 1,  1, 0, 1, 0);
    add_n(2, 1,  0, 0, 1, 0);
    // run drops on the rising-toggle cycle: toggle completes, full high phase
    add_n(1, 0,  1, 1, 1, 0);
    add_n(1, 0,  1, 0, 1, 0);
    add_n(2, 0,  0, 0, 0, 0);
    // Test 2: IDLE transfer H=3, then run: 4 high / 4 low
    add(0, 0, 1, 16'd3,  0, 0, 0, 0);
    add_n(4, 1,  0, 0, 1, 0);
    add_n(1, 1,  1, 1, 1, 0);
    add_n(3, 1,  1, 0, 1, 0);
    add_n(4, 1,  0, 0, 1, 0);
    add_n(1, 1,  1, 1, 1, 0);
    // Test 4: drop run in the 2nd high cycle; high phase still lasts 4
    add_n(1, 1,  1, 0, 1, 0);
    add_n(2, 0,  1, 0, 1, 0);
    add_n(2, 0,  0, 0, 0, 0);
    // Drop run in the low phase: IDLE on the next edge
    add_n(1, 1,  0, 0, 1, 0);
    add_n(2, 0,  0, 0, 0, 0);
    // Test 5: drop run in high, raise it one cycle later: no phase shift
    add_n(4, 1,  0, 0, 1, 0);
    add_n(1, 1,  1, 1, 1, 0);
    add_n(1, 1,  1, 0, 1, 0);
    add_n(1, 0,  1, 0, 1, 0);
    add_n(1, 1,  1, 0, 1, 0);
    add_n(4, 1,  0, 0, 1, 0);
    add_n(1, 1,  1, 1, 1, 0);
    add_n(1, 1,  1, 0, 1, 0);
    add_n(2, 0,  1, 0, 1, 0);
    add_n(1, 0,  0, 0, 0, 0);
    // Start with a same-cycle IDLE transfer of H=1
    add(0, 1, 1, 16'd1,  0, 0, 1, 0);
    add_n(1, 1,  0, 0, 1, 0);
    add_n(1, 1,  1, 1, 1, 0);
    // Test 3: transfer H=4 in the high phase; a held offer is not accepted
    add(0, 1, 1, 16'd4,  1, 0, 1, 1);
    add(0, 1, 1, 16'd7,  0, 0, 1, 0);   // falling edge applies H=4
    add_n(4, 1,  0, 0, 1, 0);           // 5 low in total
    add_n(1, 1,  1, 1, 1, 0);
    add_n(4, 1,  1, 0, 1, 0);           // 5 high in total
    // Transfer on a boundary: becomes pending, applied at the next boundary
    add(0, 1, 1, 16'd0,  0, 0, 1, 1);
    add_n(4, 1,  0, 0, 1, 1);
    add_n(1, 1,  1, 1, 1, 1);
    add_n(4, 1,  1, 0, 1, 1);
    add_n(1, 1,  0, 0, 1, 0);           // H=0 applied here
    add_n(1, 1,  1, 1, 1, 0);           // divide-by-2
    add_n(1, 1,  0, 0, 1, 0);
    add_n(1, 1,  1, 1, 1, 0);
    add_n(1, 1,  0, 0, 1, 0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Test 6: reset during a high phase with a pending config
    apply(mk(0, 1, 1, 16'd5,  1, 1, 1, 1));
    apply(mk(1, 1, 0, 16'd0,  0, 0, 0, 0));
    apply(mk(0, 1, 0, 16'd0,  0, 0, 1, 0));  // restart at DEFAULT_HALF
    apply(mk(0, 1, 0, 16'd0,  0, 0, 1, 0));
    apply(mk(0, 1, 0, 16'd0,  1, 1, 1, 0));
    apply(mk(0, 1, 0, 16'd0,  1, 0, 1, 0));
    apply(mk(0, 1, 0, 16'd0,  0, 0, 1, 0));
    apply(mk(0, 1, 0, 16'd0,  0, 0, 1, 0));
    apply(mk(0, 1, 0, 16'd0,  1, 1, 1, 0));
    apply(mk(0, 0, 0, 16'd0,  1, 0, 1, 0));  // STOPPING
    apply(mk(0, 0, 0, 16'd0,  0, 0, 0, 0));  // falling edge, IDLE, no tick

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover got=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
